// File: rtl/trng_bitsrc.sv
// Serial entropy-bit source: synchronizes a raw ring-oscillator bit, von Neumann
// debiases it, runs a repetition-count health test and buffers bits in a FIFO.
module trng_bitsrc #(
  parameter int DEPTH      = 32,
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_CUTOFF = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       en,
  input  logic                       raw_bit,
  input  logic                       trng_req,
  output logic                       trng_bit,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       health_fail,
  output logic                       underflow,
  input  logic                       clear_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
  localparam logic [7:0]    CUTOFF   = 8'(RCT_CUTOFF);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] div_cnt;
  logic          have_first;
  logic          first_bit;
  logic          prev_sample;
  logic [7:0]    rct_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [FW-1:0] count;
  logic          mem [DEPTH];

  logic       sample;
  logic       strobe;
  logic [7:0] rct_next;
  logic       rct_trip;
  logic       emit;
  logic       push;
  logic       pop;
  logic       underflow_trip;

  assign sample = sync2;
  assign strobe = en && (div_cnt == DIV_LAST);

  // rct_cnt==0 marks "no sample seen since reset/clear", so the next strobe restarts at 1
  always_comb begin
    rct_next = rct_cnt;
    if (strobe) begin
      if ((rct_cnt == 8'd0) || (sample != prev_sample)) begin
        rct_next = 8'd1;
      end else if (rct_cnt != 8'hFF) begin
        rct_next = rct_cnt + 8'd1;
      end
    end
  end

  assign rct_trip = strobe && (rct_next >= CUTOFF);

  // A 01 pair emits 0 and a 10 pair emits 1: the emitted bit is the pair's first sample
  assign emit           = strobe && have_first && (first_bit != sample);
  assign push           = emit && !health_fail && (count != DEPTH_F);
  assign pop            = trng_req && (count != '0);
  assign underflow_trip = trng_req && (count == '0);

  assign fill     = count;
  assign trng_bit = (count != '0) ? mem[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= first_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      div_cnt     <= '0;
      have_first  <= 1'b0;
      first_bit   <= 1'b0;
      prev_sample <= 1'b0;
      rct_cnt     <= 8'd0;
      health_fail <= 1'b0;
      underflow   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      sync1 <= raw_bit;
      sync2 <= sync1;

      if (!en) begin
        div_cnt    <= '0;
        have_first <= 1'b0;
      end else begin
        div_cnt <= strobe ? '0 : div_cnt + DW'(1);
        if (strobe) begin
          prev_sample <= sample;
          if (have_first) begin
            have_first <= 1'b0;
          end else begin
            have_first <= 1'b1;
            first_bit  <= sample;
          end
        end
      end

      rct_cnt <= clear_flags ? 8'd0 : rct_next;

      // A set condition in the same cycle as clear_flags keeps the flag raised
      if (rct_trip) begin
        health_fail <= 1'b1;
      end else if (clear_flags) begin
        health_fail <= 1'b0;
      end

      if (underflow_trip) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + FW'(1);
      end else if (pop && !push) begin
        count <= count - FW'(1);
      end
    end
  end

endmodule
